// File: rtl/sid_cmd_sched_pkg.sv
// rtl/sid_cmd_sched_pkg.sv - shared entry layout, delay address default and FSM encodings
package sid_cmd_sched_pkg;

    localparam logic [4:0] DELAY_ADDR_DEF = 5'h1f;
    localparam int ENTRY_W  = 13;
    localparam int DATA_LSB = 0;
    localparam int DATA_MSB = 7;
    localparam int ADDR_LSB = 8;
    localparam int ADDR_MSB = 12;

    typedef enum logic {
        P_ADDR = 1'b0,
        P_DATA = 1'b1
    } parse_state_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_WAIT  = 2'd2
    } issue_state_t;

endpackage

// File: rtl/sid_cmd_fifo.sv
// rtl/sid_cmd_fifo.sv - synchronous first-word-fall-through FIFO with simultaneous push/pop
module sid_cmd_fifo #(
    parameter int AW = 4,
    parameter int W  = 13
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    logic [W-1:0]  mem [2**AW];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign full    = count[AW];
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sid_cmd_sched.sv
// rtl/sid_cmd_sched.sv - UART byte pairs to paced SID register writes; SID_CMD_RX_TIMEOUT_EN adds parser resync
module sid_cmd_sched
    import sid_cmd_sched_pkg::*;
#(
    parameter int         FIFO_AW        = 4,
    parameter logic [4:0] DELAY_ADDR     = DELAY_ADDR_DEF,
    parameter int         WAIT_W         = 8,
    parameter int         TIMEOUT_CYCLES = 120000
) (
    input  logic       CLK_IN,
    input  logic       RSTn_i,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    input  logic       ce_1m,
    output logic       sid_we,
    output logic [4:0] sid_addr,
    output logic [7:0] sid_data,
    output logic       fifo_full,
    output logic       overflow,
    output logic       busy
);

    parse_state_t        p_state, p_next;
    issue_state_t        s_state, s_next;
    logic [4:0]          addr_lat;
    logic                push_req;
    logic                pop;
    logic                fifo_empty;
    logic [ENTRY_W-1:0]  fifo_dout;
    logic [4:0]          head_addr;
    logic [7:0]          head_data;
    logic [WAIT_W-1:0]   wcnt, wcnt_next;
    logic                we_next;
    logic [4:0]          addr_next;
    logic [7:0]          data_next;
    logic                tmo_hit;

    assign push_req  = rx_valid && (p_state == P_DATA);
    assign head_addr = fifo_dout[ADDR_MSB:ADDR_LSB];
    assign head_data = fifo_dout[DATA_MSB:DATA_LSB];
    assign busy      = !fifo_empty || (s_state != S_IDLE);

    sid_cmd_fifo #(.AW(FIFO_AW), .W(ENTRY_W)) u_fifo (
        .clk   (CLK_IN),
        .rst_n (RSTn_i),
        .push  (push_req),
        .pop   (pop),
        .din   ({addr_lat, rx_byte}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef SID_CMD_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;

    // Counter sits at zero in P_ADDR, so it restarts on every entry into P_DATA.
    always_ff @(posedge CLK_IN or negedge RSTn_i) begin
        if (!RSTn_i) begin
            tmo_cnt <= '0;
        end else if (p_state == P_ADDR || rx_valid) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign tmo_hit = (p_state == P_DATA) && !rx_valid && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge CLK_IN or negedge RSTn_i) begin
        if (!RSTn_i) begin
            p_state  <= P_ADDR;
            addr_lat <= '0;
            overflow <= 1'b0;
        end else begin
            p_state <= p_next;
            if (rx_valid && p_state == P_ADDR) begin
                addr_lat <= rx_byte[4:0];
            end
            if (push_req && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        p_next = p_state;
        if (tmo_hit) begin
            p_next = P_ADDR;
        end else if (rx_valid) begin
            p_next = (p_state == P_ADDR) ? P_DATA : P_ADDR;
        end
    end

    always_ff @(posedge CLK_IN or negedge RSTn_i) begin
        if (!RSTn_i) begin
            s_state  <= S_IDLE;
            wcnt     <= '0;
            sid_we   <= 1'b0;
            sid_addr <= '0;
            sid_data <= '0;
        end else begin
            s_state  <= s_next;
            wcnt     <= wcnt_next;
            sid_we   <= we_next;
            sid_addr <= addr_next;
            sid_data <= data_next;
        end
    end

    always_comb begin
        s_next = s_state;
        if (ce_1m) begin
            if (s_state == S_WAIT && wcnt != '0) begin
                s_next = S_WAIT;
            end else if (!fifo_empty) begin
                s_next = (head_addr == DELAY_ADDR) ? S_WAIT : S_WRITE;
            end else begin
                s_next = S_IDLE;
            end
        end
    end

    // The delay entry takes its own slot, then wcnt more, giving data+1 idle SID cycles.
    always_comb begin
        pop       = 1'b0;
        wcnt_next = wcnt;
        we_next   = sid_we;
        addr_next = sid_addr;
        data_next = sid_data;
        if (ce_1m) begin
            if (s_state == S_WAIT && wcnt != '0) begin
                wcnt_next = wcnt - 1'b1;
                we_next   = 1'b0;
            end else if (!fifo_empty) begin
                pop = 1'b1;
                if (head_addr == DELAY_ADDR) begin
                    wcnt_next = WAIT_W'(head_data);
                    we_next   = 1'b0;
                end else begin
                    we_next   = 1'b1;
                    addr_next = head_addr;
                    data_next = head_data;
                end
            end else begin
                we_next = 1'b0;
            end
        end
    end

endmodule
